// File: rtl/m_wbgpio_pkg.sv
// Shared address map and byte-lane helper for the midgetv Wishbone GPIO slave.
package m_wbgpio_pkg;

    localparam logic [3:0] A_OUT    = 4'd0;
    localparam logic [3:0] A_OUTSET = 4'd1;
    localparam logic [3:0] A_OUTCLR = 4'd2;
    localparam logic [3:0] A_IN     = 4'd3;
    localparam logic [3:0] A_DUTY0  = 4'd4;

    // Expand SEL into a 32-bit bit mask, one byte per select line.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int unsigned b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/m_wbgpio_if.sv
// Wishbone classic bus bundle between m_midgetv_core and the GPIO slave.
interface m_wbgpio_if;

    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic [3:0]  ADR_I;
    logic [31:0] DAT_I;
    logic [3:0]  SEL_I;
    logic [31:0] DAT_O;
    logic        ACK_O;

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I,
        input  DAT_O, ACK_O
    );

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I,
        output DAT_O, ACK_O
    );

endinterface

// File: rtl/m_pwmchan.sv
// One PWM channel: bus-written shadow duty, reloaded into the active duty at counter wrap.
module m_pwmchan #(
    parameter int PWMBITS = 8
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    input  logic [PWMBITS-1:0] cnt,
    input  logic               wrap,
    input  logic               wr,
    input  logic [PWMBITS-1:0] duty,
    output logic [PWMBITS-1:0] shadow,
    output logic               pwm_o
);

    logic [PWMBITS-1:0] active;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            shadow <= '0;
            active <= '0;
            pwm_o  <= 1'b0;
        end else begin
            if (wr) begin
                shadow <= duty;
            end
            // A write on the wrap edge is seen by active only at the next wrap.
            if (wrap) begin
                active <= shadow;
            end
            pwm_o <= (cnt < active);
        end
    end

endmodule

// File: rtl/m_wbgpio.sv
// Wishbone classic GPIO slave: output port with set/clear aliases, synchronised inputs, LED PWM.
module m_wbgpio
    import m_wbgpio_pkg::*;
#(
    parameter int          NOUT       = 4,
    parameter int          NIN        = 1,
    parameter int          SYNCSTAGES = 2,
    parameter int          NPWM       = 3,
    parameter int          PWMBITS    = 8,
    parameter logic [31:0] OUTRST     = 32'h1
) (
    input  logic                             CLK_I,
    input  logic                             RST_I,
    m_wbgpio_if.slave                        wb,
    output logic [NOUT-1:0]                  gpo,
    input  logic [NIN-1:0]                   gpi,
    output logic [((NPWM > 0) ? NPWM : 1)-1:0] pwm_o
);

    localparam int NPW = (NPWM > 0) ? NPWM : 1;

    logic                             req;
    logic                             wr;
    logic [NOUT-1:0]                  gmask;
    logic [NOUT-1:0]                  gdat;
    logic [PWMBITS-1:0]               dmask;
    logic [PWMBITS-1:0]               ddat;
    logic [SYNCSTAGES-1:0][NIN-1:0]   sync_q;
    logic [PWMBITS-1:0]               cnt;
    logic                             wrap;
    logic [PWMBITS-1:0]               shadow [NPW];
    logic [31:0]                      rdata;

    assign req   = wb.CYC_I & wb.STB_I & ~wb.ACK_O;
    assign wr    = req & wb.WE_I;
    assign gmask = NOUT'(lane_mask(wb.SEL_I));
    assign gdat  = NOUT'(wb.DAT_I) & gmask;
    assign dmask = PWMBITS'(lane_mask(wb.SEL_I));
    assign ddat  = PWMBITS'(wb.DAT_I) & dmask;
    assign wrap  = &cnt;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wb.ACK_O <= 1'b0;
            wb.DAT_O <= '0;
        end else begin
            wb.ACK_O <= req;
            if (req) begin
                wb.DAT_O <= rdata;
            end
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            gpo <= NOUT'(OUTRST);
        end else if (wr) begin
            case (wb.ADR_I)
                A_OUT:    gpo <= (gpo & ~gmask) | gdat;
                A_OUTSET: gpo <= gpo | gdat;
                A_OUTCLR: gpo <= gpo & ~gdat;
                default:  gpo <= gpo;
            endcase
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            sync_q <= '0;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[SYNCSTAGES-2:0], gpi};
            cnt    <= cnt + 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        case (wb.ADR_I)
            A_OUT, A_OUTSET, A_OUTCLR: rdata = 32'(gpo);
            A_IN:                      rdata = 32'(sync_q[SYNCSTAGES-1]);
            default: begin
                for (int unsigned k = 0; k < unsigned'(NPWM); k++) begin
                    if (wb.ADR_I == 4'(32'(A_DUTY0) + k)) begin
                        rdata = 32'(shadow[k]);
                    end
                end
            end
        endcase
    end

    generate
        if (NPWM > 0) begin : g_pwm
            for (genvar k = 0; k < NPWM; k++) begin : g_ch
                m_pwmchan #(
                    .PWMBITS(PWMBITS)
                ) u_ch (
                    .CLK_I (CLK_I),
                    .RST_I (RST_I),
                    .cnt   (cnt),
                    .wrap  (wrap),
                    .wr    (wr && (wb.ADR_I == 4'(int'(A_DUTY0) + k))),
                    .duty  ((shadow[k] & ~dmask) | ddat),
                    .shadow(shadow[k]),
                    .pwm_o (pwm_o[k])
                );
            end
        end else begin : g_nopwm
            assign pwm_o     = '0;
            assign shadow[0] = '0;
        end
    endgenerate

endmodule
